// File: rtl/lsh_pkg.sv
// lsh_pkg
// Shared constants and types for the LSH hit counter.
//   DEF_*        default parameter values for lsh_hit_counter
//   lsh_state_t  scan controller state (IDLE, SCAN)
//   countWidth   bits needed to hold a match count of 0..nb
package lsh_pkg;

  localparam int DEF_MAX_WINDOWS = 512;
  localparam int DEF_BUCKET_SIZE = 16;
  localparam int DEF_NUM_BANDS   = 4;
  localparam int DEF_LANES       = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } lsh_state_t;

  function automatic int countWidth(input int nb);
    return $clog2(nb + 1);
  endfunction

endpackage

// File: rtl/lsh_band_match.sv
// lsh_band_match
// Counts how many bands of one reference window match the query.
//   i_hash   NUM_BANDS x BUCKET_SIZE  stored band hashes (band b at [b*BUCKET_SIZE +: BUCKET_SIZE])
//   i_valid  NUM_BANDS                per-band valid bits
//   i_query  NUM_BANDS x BUCKET_SIZE  latched query band hashes
//   o_count  CW                       number of valid matching bands
module lsh_band_match #(
  parameter int BUCKET_SIZE = lsh_pkg::DEF_BUCKET_SIZE,
  parameter int NUM_BANDS   = lsh_pkg::DEF_NUM_BANDS,
  parameter int CW          = lsh_pkg::countWidth(lsh_pkg::DEF_NUM_BANDS)
) (
  input  logic [NUM_BANDS*BUCKET_SIZE-1:0] i_hash,
  input  logic [NUM_BANDS-1:0]             i_valid,
  input  logic [NUM_BANDS*BUCKET_SIZE-1:0] i_query,
  output logic [CW-1:0]                    o_count
);

  // A band only counts when it has actually been written, so an unwritten
  // band never matches, even against a query hash of zero.
  always_comb begin
    o_count = '0;
    for (int b = 0; b < NUM_BANDS; b++) begin
      if (i_valid[b] &&
          (i_hash[b*BUCKET_SIZE +: BUCKET_SIZE] == i_query[b*BUCKET_SIZE +: BUCKET_SIZE])) begin
        o_count = o_count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/lsh_hit_counter.sv
// lsh_hit_counter
// Reference table of band hashes plus a LANES-wide scanner that builds the
// per-window band-match count for each accepted query.
//   clk, reset_stats      clock, asynchronous active-high reset
//   ref_wr_*              write one band hash of one reference window (IDLE only)
//   q_valid / q_ready     query handshake; q_hash holds all band hashes
//   is_query              high while the current query's counts are being built
//   count_bus             per-window match count, 32 bits per window
module lsh_hit_counter
  import lsh_pkg::*;
#(
  parameter int MAX_WINDOWS_IN_REFERENCE = DEF_MAX_WINDOWS,
  parameter int BUCKET_SIZE              = DEF_BUCKET_SIZE,
  parameter int NUM_BANDS                = DEF_NUM_BANDS,
  parameter int LANES                    = DEF_LANES
) (
  input  logic                                   clk,
  input  logic                                   reset_stats,
  input  logic                                   ref_wr_en,
  input  logic [$clog2(MAX_WINDOWS_IN_REFERENCE)-1:0] ref_wr_addr,
  input  logic [$clog2(NUM_BANDS)-1:0]           ref_wr_band,
  input  logic [BUCKET_SIZE-1:0]                 ref_wr_hash,
  input  logic                                   q_valid,
  output logic                                   q_ready,
  input  logic [NUM_BANDS*BUCKET_SIZE-1:0]       q_hash,
  output logic                                   is_query,
  output logic [MAX_WINDOWS_IN_REFERENCE*32-1:0] count_bus
);

  localparam int AW    = $clog2(MAX_WINDOWS_IN_REFERENCE);
  localparam int CW    = countWidth(NUM_BANDS);
  localparam int SCANS = MAX_WINDOWS_IN_REFERENCE / LANES;
  localparam int SW    = (SCANS > 1) ? $clog2(SCANS) : 1;
  localparam logic [SW-1:0] LAST_IDX = SW'(SCANS - 1);

  lsh_state_t r_state;
  lsh_state_t w_nextState;

  logic [SW-1:0]                    r_scanIdx;
  logic [NUM_BANDS*BUCKET_SIZE-1:0] r_qHash;
  logic [BUCKET_SIZE-1:0]           r_hash  [MAX_WINDOWS_IN_REFERENCE][NUM_BANDS];
  logic [NUM_BANDS-1:0]             r_valid [MAX_WINDOWS_IN_REFERENCE];
  logic [CW-1:0]                    r_count [MAX_WINDOWS_IN_REFERENCE];

  logic [AW-1:0] w_laneWin [LANES];
  logic [CW-1:0] w_laneCnt [LANES];
  logic          w_accept;
  logic          w_wrCommit;
  logic          w_lastScan;

  assign w_accept   = q_valid && (r_state == IDLE);
  assign w_wrCommit = ref_wr_en && (r_state == IDLE);
  assign w_lastScan = (r_state == SCAN) && (r_scanIdx == LAST_IDX);

  assign q_ready  = (r_state == IDLE);
  assign is_query = (r_state == SCAN);

  always_ff @(posedge clk or posedge reset_stats) begin
    if (reset_stats) r_state <= IDLE;
    else             r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (q_valid) w_nextState = SCAN;
      SCAN:    if (w_lastScan) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Scan index wraps back to 0 on the final slice, so it is already cleared
  // for the next query as well as on accept.
  always_ff @(posedge clk or posedge reset_stats) begin
    if (reset_stats) begin
      r_scanIdx <= '0;
    end else if (w_accept) begin
      r_scanIdx <= '0;
    end else if (r_state == SCAN) begin
      r_scanIdx <= w_lastScan ? '0 : r_scanIdx + SW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset_stats) begin
    if (reset_stats)   r_qHash <= '0;
    else if (w_accept) r_qHash <= q_hash;
  end

  // Hash storage is deliberately left unreset; the valid bits decide
  // whether an entry can ever match.
  always_ff @(posedge clk) begin
    if (w_wrCommit) r_hash[ref_wr_addr][ref_wr_band] <= ref_wr_hash;
  end

  always_ff @(posedge clk or posedge reset_stats) begin
    if (reset_stats) begin
      for (int w = 0; w < MAX_WINDOWS_IN_REFERENCE; w++) r_valid[w] <= '0;
    end else if (w_wrCommit) begin
      r_valid[ref_wr_addr][ref_wr_band] <= 1'b1;
    end
  end

  // Counts are cleared on accept so nothing from the previous query leaks
  // into windows the scan has not reached yet.
  always_ff @(posedge clk or posedge reset_stats) begin
    if (reset_stats) begin
      for (int w = 0; w < MAX_WINDOWS_IN_REFERENCE; w++) r_count[w] <= '0;
    end else if (w_accept) begin
      for (int w = 0; w < MAX_WINDOWS_IN_REFERENCE; w++) r_count[w] <= '0;
    end else if (r_state == SCAN) begin
      for (int l = 0; l < LANES; l++) r_count[w_laneWin[l]] <= w_laneCnt[l];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [NUM_BANDS*BUCKET_SIZE-1:0] w_hashVec;

    assign w_laneWin[l] = AW'(r_scanIdx) * AW'(LANES) + AW'(l);

    always_comb begin
      w_hashVec = '0;
      for (int b = 0; b < NUM_BANDS; b++) begin
        w_hashVec[b*BUCKET_SIZE +: BUCKET_SIZE] = r_hash[w_laneWin[l]][b];
      end
    end

    lsh_band_match #(
      .BUCKET_SIZE(BUCKET_SIZE),
      .NUM_BANDS  (NUM_BANDS),
      .CW         (CW)
    ) u_match (
      .i_hash (w_hashVec),
      .i_valid(r_valid[w_laneWin[l]]),
      .i_query(r_qHash),
      .o_count(w_laneCnt[l])
    );
  end

  for (genvar w = 0; w < MAX_WINDOWS_IN_REFERENCE; w++) begin : g_bus
    assign count_bus[w*32 +: 32] = 32'(r_count[w]);
  end

endmodule
